// File: rtl/bin_search_sched_pkg.sv
// Purpose : shared types and defaults for the binary-search scheduler slice.
// Contents: scheduler state enum, default key/index widths, default watchdog
//           length and the watchdog timer width helper.
package bin_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned KEY_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned TIMEOUT_DEF = 15;

  // Timer must be able to hold TIMEOUT itself (it counts through TIMEOUT-1).
  function automatic int unsigned timer_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bin_search_sched_if.sv
// Purpose : requester-side bus between the front-ends and the scheduler.
// Signals : req   - per-requester request level, held until ack
//           key   - packed keys, requester i at [i*KEY_W +: KEY_W]
//           ack   - one-cycle response strobe to the owning requester
//           rsp_found / rsp_index / rsp_timeout - registered result
// Modports: master = requesters, slave = scheduler.
interface bin_search_sched_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned KEY_W  = 8,
  parameter int unsigned ADDR_W = 5
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*KEY_W-1:0] key;
  logic [NREQ-1:0]       ack;
  logic                  rsp_found;
  logic [ADDR_W-1:0]     rsp_index;
  logic                  rsp_timeout;

  modport master (
    output req, key,
    input  ack, rsp_found, rsp_index, rsp_timeout
  );

  modport slave (
    input  req, key,
    output ack, rsp_found, rsp_index, rsp_timeout
  );

endinterface

// File: rtl/bin_search_sched_rr_arbiter.sv
// Purpose : combinational round-robin picker.
// Ports   : req         - request vector
//           pointer     - index searched first; search wraps upward
//           grant_valid - at least one request present
//           grant_idx   - first set request at or after pointer
module rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] pointer,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  always_comb begin
    int unsigned w_j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_j         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = (32'(pointer) + k) % NREQ;
      if (!grant_valid && req[w_j]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/bin_search_sched.sv
// Purpose : shares one binary-search engine among NREQ requesters. A pending
//           request is picked round-robin, its key latched and the engine
//           started; the result (or a watchdog timeout) is returned to the
//           owner together with a one-cycle ack.
// Ports   : clk, reset (async, active-low)
//           bus        - requester bus (slave modport of bin_search_sched_if)
//           busy       - scheduler not in IDLE
//           eng_start  - engine start level (ISSUE and WAIT)
//           eng_key    - latched key presented to the engine
//           eng_done / eng_found / eng_index - engine result, sampled in WAIT
module bin_search_sched
  import bin_search_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned KEY_W   = KEY_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  bin_search_sched_if.slave bus,
  output logic              busy,
  output logic              eng_start,
  output logic [KEY_W-1:0]  eng_key,
  input  logic              eng_done,
  input  logic              eng_found,
  input  logic [ADDR_W-1:0] eng_index
);

  localparam int unsigned TMR_W = timer_width(TIMEOUT);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [TMR_W-1:0]   r_timer;
  logic [KEY_W-1:0]   r_eng_key;
  logic               r_rsp_found;
  logic [ADDR_W-1:0]  r_rsp_index;
  logic               r_rsp_timeout;

  logic               w_grant_valid;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_tmo;
  logic [NREQ-1:0]    w_ack;
  logic [PTR_W-1:0]   w_ptr_nxt;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req         (bus.req),
    .pointer     (r_ptr),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  assign w_tmo     = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_ptr_nxt = PTR_W'((32'(r_owner) + 1) % NREQ);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; eng_done wins over a coincident watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_grant_valid) w_state_nxt = ISSUE;
      ISSUE: w_state_nxt = WAIT;
      WAIT:  if (eng_done || w_tmo) w_state_nxt = RESP;
      RESP:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: owner/key latches, watchdog timer, result registers, pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr         <= '0;
      r_owner       <= '0;
      r_timer       <= '0;
      r_eng_key     <= '0;
      r_rsp_found   <= 1'b0;
      r_rsp_index   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner   <= w_grant_idx;
            r_eng_key <= bus.key[32'(w_grant_idx)*KEY_W +: KEY_W];
          end
        end
        ISSUE: r_timer <= '0;
        WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          if (eng_done) begin
            r_rsp_found   <= eng_found;
            r_rsp_index   <= eng_found ? eng_index : '0;
            r_rsp_timeout <= 1'b0;
          end else if (w_tmo) begin
            r_rsp_found   <= 1'b0;
            r_rsp_index   <= '0;
            r_rsp_timeout <= 1'b1;
          end
        end
        RESP: r_ptr <= w_ptr_nxt;
        default: ;
      endcase
    end
  end

  // Decoded from state so that reset removes ack and eng_start immediately.
  always_comb begin
    w_ack = '0;
    if (r_state == RESP) w_ack[r_owner] = 1'b1;
  end

  assign busy            = (r_state != IDLE);
  assign eng_start       = (r_state == ISSUE) || (r_state == WAIT);
  assign eng_key         = r_eng_key;
  assign bus.ack         = w_ack;
  assign bus.rsp_found   = r_rsp_found;
  assign bus.rsp_index   = r_rsp_index;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/bin_search_sched.md
# bin_search_sched

Round-robin scheduler that shares one binary-search engine (FSM + datapath searching a 32-entry sorted memory for an 8-bit key) among several requesters. The scheduler picks one pending request and latches its key, then starts the engine and waits for done or a watchdog timeout. It returns found/index to the winning requester with a one-cycle ack. It sits between the requesting front-ends (switch/UI logic, self-test) and the search engine, which is never driven directly by requesters.

## Interface
- NREQ, 2, number of requesters (2..4)
- KEY_W, 8, search key width
- ADDR_W, 5, engine index width (memory depth 2^ADDR_W)
- TIMEOUT, 15, max cycles in WAIT before aborting (must exceed ADDR_W+2)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level, held until ack
- key  in  NREQ*KEY_W  packed keys, requester i at [i*KEY_W +: KEY_W], stable while req[i]=1
- ack  out  NREQ  one-cycle response strobe to owner
- rsp_found  out  1  result valid with ack: key present
- rsp_index  out  ADDR_W  matching address, valid only when rsp_found=1 (else 0)
- rsp_timeout  out  1  engine did not finish; rsp_found=0
- busy  out  1  1 in any state other than IDLE
- eng_start  out  1  engine start level
- eng_key  out  KEY_W  key to engine
- eng_done  in  1  engine finished (sampled only in WAIT)
- eng_found  in  1  engine result
- eng_index  in  ADDR_W  engine result address

## Operation
- Reset (reset=0, async): state IDLE, rr pointer 0, owner 0, timer 0; all outputs 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit set, grant first set bit searching from pointer upward with wrap (pointer, pointer+1, …, NREQ-1, 0, …); latch owner and key[owner] into eng_key; -> ISSUE. Else stay.
- ISSUE: eng_start=1, timer cleared; -> WAIT.
- WAIT: eng_start=1; timer increments each cycle.
  - eng_done=1: capture eng_found, eng_index (index forced 0 if not found), rsp_timeout=0; -> RESP.
  - else timer==TIMEOUT-1: rsp_found=0, rsp_index=0, rsp_timeout=1; -> RESP.
  - eng_done and timeout in same cycle: done wins.
- RESP: eng_start=0; ack[owner]=1 for exactly this cycle, rsp_* held; pointer <= (owner+1) mod NREQ; -> IDLE.
- rsp_* registered; hold last value until next RESP overwrites it.
- eng_done outside WAIT ignored (late done after timeout is dropped).
- Requester rule: drop req[i] on the edge after ack[i]; req still high when IDLE samples it is a new request.
- Requests arriving while busy wait; no queueing beyond req levels. Changing key or dropping req before ack is a protocol violation (scheduler uses latched key; dropped request still acked).

## Timing
- Grant latency: req sampled in IDLE at edge n -> ISSUE at n+1 (eng_start rises), WAIT at n+2.
- Engine done seen in WAIT cycle m -> ack during cycle m+1 -> IDLE at m+2.
- Minimum turnaround with engine done in first WAIT cycle: 4 cycles request-to-IDLE.
- Timeout path: ack in cycle ISSUE+TIMEOUT+1.
- Back-to-back: next grant earliest in IDLE cycle right after RESP; no idle gaps enforced.
- Reset mid-operation: immediate return to IDLE, eng_start and ack drop asynchronously; no ack emitted for the aborted request.

## Structure
- Package bin_search_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default KEY_W/ADDR_W constants, timer width as $clog2(TIMEOUT+1).
- Sub-module rr_arbiter (combinational): inputs req, pointer; outputs grant_valid, grant_idx. Scheduler instantiates one.
- Top: FSM, key/owner latches, timer, result registers.

## Test plan
- Single request: req=01, key0=8'h2A, engine model done after 5 cycles with found=1, index=5'd13 -> ack=01 once, rsp_found=1, rsp_index=13, rsp_timeout=0, eng_key=2A during ISSUE/WAIT.
- Round-robin fairness: req=11 held continuously, keys 8'h10/8'h20 -> grants alternate 0,1,0,1; eng_key alternates 10,20.
- Not found: engine done with found=0, index=5'd7 -> rsp_found=0, rsp_index=0, ack to owner.
- Timeout: engine never asserts done, TIMEOUT=15 -> ack exactly 16 cycles after ISSUE, rsp_timeout=1; later stray eng_done ignored, state stays IDLE.
- Simultaneous done and timeout on cycle 15 -> rsp_timeout=0, engine result reported.
- Reset asserted during WAIT -> busy, eng_start, ack all 0 immediately; after release, pending req=10 granted to requester 1 (pointer back to 0, bit 1 first set).
